// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: Moore-decoded enables,
// memory-ready stalls, sticky illegal-opcode halt and retired-instruction count.
//
// state   | meaning
// FETCH   | read instruction at PC, PC += 4 on mem_ready
// DECODE  | branch target into ALUOut, dispatch on opcode
// MEMADR  | compute load/store address
// MEMRD   | load read, stall on mem_ready
// MEMWB   | load writeback from MDR
// MEMWR   | store write, stall on mem_ready
// RTEXEC  | R-type ALU operation
// RTWB    | R-type writeback to rd
// IMMEXEC | immediate ALU operation
// IMMWB   | immediate writeback to rt
// BRANCH  | compare and conditional PC load
// JUMP    | jump target into PC
// HALT    | illegal opcode, exit only by reset
module mips_multicycle_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        branch_ne,
  output logic [1:0]  pc_src,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        imm_zext,
  output logic [3:0]  alu_op,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXEC  = 4'd6,
    S_RTWB    = 4'd7,
    S_IMMEXEC = 4'd8,
    S_IMMWB   = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state_r, state_nx;
  logic   retire;
  logic   imm_is_logic;
  logic [3:0] imm_alu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
      illegal <= 1'b0;
      retired <= 32'd0;
    end else begin
      state_r <= state_nx;
      if (state_nx == S_HALT) illegal <= 1'b1;
      if (retire) retired <= retired + 32'd1;
    end
  end

  // Immediate ALU op is decoded from opcode in both IMMEXEC and IMMWB; the IR holds it stable.
  always_comb begin
    imm_alu_op   = 4'b0011;
    imm_is_logic = 1'b0;
    case (opcode)
      OP_ANDI:          begin imm_alu_op = 4'b0100; imm_is_logic = 1'b1; end
      OP_ORI:           begin imm_alu_op = 4'b0101; imm_is_logic = 1'b1; end
      OP_SLTI, OP_SLTIU: imm_alu_op = 4'b0110;
      default:          imm_alu_op = 4'b0011;
    endcase
  end

  always_comb begin
    state_nx      = state_r;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_src        = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    imm_zext      = 1'b0;
    alu_op        = 4'b0000;
    case (state_r)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:                                 state_nx = S_MEMADR;
          OP_RTYPE:                                     state_nx = S_RTEXEC;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_SLTIU:  state_nx = S_IMMEXEC;
          OP_BEQ, OP_BNE:                               state_nx = S_BRANCH;
          OP_J:                                         state_nx = S_JUMP;
          default:                                      state_nx = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_nx  = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_nx = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_nx   = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_nx = S_FETCH;
      end
      S_RTEXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 4'b0010;
        state_nx  = S_RTWB;
      end
      S_RTWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_nx  = S_FETCH;
      end
      S_IMMEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = imm_alu_op;
        imm_zext  = imm_is_logic;
        state_nx  = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        alu_op    = imm_alu_op;
        imm_zext  = imm_is_logic;
        state_nx  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 4'b0001;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        branch_ne     = opcode[0];
        state_nx      = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_nx = S_FETCH;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

  // Only instruction-ending states count; FETCH self-loops during stalls do not.
  always_comb begin
    retire = 1'b0;
    if (state_nx == S_FETCH) begin
      case (state_r)
        S_MEMWB, S_MEMWR, S_RTWB, S_IMMWB, S_BRANCH, S_JUMP: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: per-scenario tasks with inline
// checks against hand-computed state sequences and decoded enables.
module tb_mips_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, branch_ne;
  logic [1:0]  pc_src;
  logic        iord, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b;
  logic        imm_zext;
  logic [3:0]  alu_op;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] retired;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_retired = 32'd0;

  mips_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_src(pc_src), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_zext(imm_zext), .alu_op(alu_op), .state(state), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b100011;
    #3;
    total++;
    if (state !== 4'd0 || illegal !== 1'b0 || retired !== 32'd0)
      $display("FAIL reset_regs state=%0d illegal=%0b retired=%0d want 0/0/0", state, illegal, retired);
    else passed++;
    total++;
    if (mem_read !== 1'b1 || alu_src_b !== 2'b01 || alu_op !== 4'b0000 || ir_write !== 1'b1 || pc_write !== 1'b1)
      $display("FAIL reset_fetch_decode mem_read=%0b alu_src_b=%0b alu_op=%0b ir_write=%0b pc_write=%0b want 1/01/0000/1/1",
               mem_read, alu_src_b, alu_op, ir_write, pc_write);
    else passed++;
    step();
    rst_n = 1'b1;
    exp_retired = 32'd0;
  endtask

  task automatic test_lw;
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    opcode = 6'b100011; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (state !== seq[i] || reg_write !== (seq[i] == 4'd4) || mem_to_reg !== (seq[i] == 4'd4))
        $display("FAIL lw_seq[%0d] state=%0d reg_write=%0b mem_to_reg=%0b want state=%0d", i, state, reg_write, mem_to_reg, seq[i]);
      else passed++;
      step();
    end
    exp_retired++;
    total++;
    if (state !== 4'd0 || retired !== exp_retired)
      $display("FAIL lw_retire state=%0d retired=%0d want 0/%0d", state, retired, exp_retired);
    else passed++;
  endtask

  task automatic test_rtype;
    opcode = 6'b000000; mem_ready = 1'b1;
    step(); step();
    total++;
    if (state !== 4'd6 || alu_op !== 4'b0010 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00)
      $display("FAIL rtexec state=%0d alu_op=%0b alu_src_a=%0b want 6/0010/1", state, alu_op, alu_src_a);
    else passed++;
    step();
    total++;
    if (state !== 4'd7 || reg_dst !== 1'b1 || reg_write !== 1'b1 || mem_to_reg !== 1'b0)
      $display("FAIL rtwb state=%0d reg_dst=%0b reg_write=%0b want 7/1/1", state, reg_dst, reg_write);
    else passed++;
    step();
    exp_retired++;
    total++;
    if (state !== 4'd0 || retired !== exp_retired)
      $display("FAIL rtype_retire state=%0d retired=%0d want 0/%0d", state, retired, exp_retired);
    else passed++;
  endtask

  task automatic test_ori;
    opcode = 6'b001101; mem_ready = 1'b1;
    step(); step();
    total++;
    if (state !== 4'd8 || alu_op !== 4'b0101 || imm_zext !== 1'b1 || alu_src_b !== 2'b10)
      $display("FAIL ori_exec state=%0d alu_op=%0b imm_zext=%0b want 8/0101/1", state, alu_op, imm_zext);
    else passed++;
    step();
    total++;
    if (state !== 4'd9 || alu_op !== 4'b0101 || imm_zext !== 1'b1 || reg_write !== 1'b1 || reg_dst !== 1'b0)
      $display("FAIL ori_wb state=%0d alu_op=%0b imm_zext=%0b reg_write=%0b want 9/0101/1/1", state, alu_op, imm_zext, reg_write);
    else passed++;
    step();
    exp_retired++;
    // slti: sign-extended, alu_op 0110
    opcode = 6'b001010;
    step(); step();
    total++;
    if (state !== 4'd8 || alu_op !== 4'b0110 || imm_zext !== 1'b0)
      $display("FAIL slti_exec state=%0d alu_op=%0b imm_zext=%0b want 8/0110/0", state, alu_op, imm_zext);
    else passed++;
    step(); step();
    exp_retired++;
  endtask

  task automatic test_sw_stall;
    int mw_cycles = 0;
    opcode = 6'b101011; mem_ready = 1'b1;
    step(); step(); step();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      if (state == 4'd5 && mem_write === 1'b1 && iord === 1'b1) mw_cycles++;
      step();
    end
    total++;
    if (mw_cycles !== 4)
      $display("FAIL sw_stall_cycles got=%0d want 4", mw_cycles);
    else passed++;
    exp_retired++;
    total++;
    if (state !== 4'd0 || retired !== exp_retired)
      $display("FAIL sw_retire state=%0d retired=%0d want 0/%0d", state, retired, exp_retired);
    else passed++;
  endtask

  task automatic test_branch_jump;
    opcode = 6'b000101; mem_ready = 1'b1;
    step(); step();
    total++;
    if (state !== 4'd10 || alu_op !== 4'b0001 || branch_ne !== 1'b1 || pc_write_cond !== 1'b1 || pc_src !== 2'b01)
      $display("FAIL bne state=%0d alu_op=%0b branch_ne=%0b pwc=%0b pc_src=%0b want 10/0001/1/1/01",
               state, alu_op, branch_ne, pc_write_cond, pc_src);
    else passed++;
    step();
    exp_retired++;
    opcode = 6'b000010;
    step(); step();
    total++;
    if (state !== 4'd11 || pc_src !== 2'b10 || pc_write !== 1'b1)
      $display("FAIL jump state=%0d pc_src=%0b pc_write=%0b want 11/10/1", state, pc_src, pc_write);
    else passed++;
    step();
    exp_retired++;
    total++;
    if (state !== 4'd0 || retired !== exp_retired)
      $display("FAIL bj_retire state=%0d retired=%0d want 0/%0d", state, retired, exp_retired);
    else passed++;
  endtask

  task automatic test_illegal;
    opcode = 6'b111111; mem_ready = 1'b1;
    step();
    total++;
    if (state !== 4'd1 || illegal !== 1'b0)
      $display("FAIL illegal_decode state=%0d illegal=%0b want 1/0", state, illegal);
    else passed++;
    step();
    for (int i = 0; i < 4; i++) begin
      mem_ready = i[0];
      step();
    end
    total++;
    if (state !== 4'd15 || illegal !== 1'b1 || mem_read !== 1'b0 || reg_write !== 1'b0 || pc_write !== 1'b0)
      $display("FAIL halt_sticky state=%0d illegal=%0b mem_read=%0b reg_write=%0b want 15/1/0/0", state, illegal, mem_read, reg_write);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (state !== 4'd0 || illegal !== 1'b0 || retired !== 32'd0)
      $display("FAIL halt_reset state=%0d illegal=%0b retired=%0d want 0/0/0", state, illegal, retired);
    else passed++;
    step();
    rst_n = 1'b1;
    exp_retired = 32'd0;
  endtask

  task automatic test_fetch_stall_async_reset;
    opcode = 6'b100011; mem_ready = 1'b0;
    #1;
    total++;
    if (ir_write !== 1'b0 || pc_write !== 1'b0 || mem_read !== 1'b1)
      $display("FAIL fetch_stall ir_write=%0b pc_write=%0b mem_read=%0b want 0/0/1", ir_write, pc_write, mem_read);
    else passed++;
    step(); step();
    total++;
    if (state !== 4'd0)
      $display("FAIL fetch_hold state=%0d want 0", state);
    else passed++;
    mem_ready = 1'b1;
    step(); step(); step();
    mem_ready = 1'b0;
    step();
    total++;
    if (state !== 4'd3 || mem_read !== 1'b1 || iord !== 1'b1)
      $display("FAIL memrd_stall state=%0d mem_read=%0b iord=%0b want 3/1/1", state, mem_read, iord);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (state !== 4'd0 || retired !== 32'd0)
      $display("FAIL async_reset_memrd state=%0d retired=%0d want 0/0", state, retired);
    else passed++;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_ori();
    test_sw_stall();
    test_branch_jump();
    test_illegal();
    test_fetch_stall_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control FSM for the multicycle MIPS datapath. Decodes the 6-bit opcode held in the instruction register, sequences fetch/decode/execute/memory/writeback one step per clock, and drives every datapath enable, including the 4-bit ALU-op code consumed by the ALU-control decoder. Memory accesses stall on a ready handshake. A retired-instruction counter and a sticky illegal-opcode halt support bring-up and debug.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction[31:26] from the instruction register
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if the branch condition holds
- branch_ne  out  1  branch condition: 0 = zero flag, 1 = not-zero flag
- pc_src  out  2  PC source: 00 ALU result, 01 ALUOut register, 10 jump target
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- ir_write  out  1  instruction register load
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-data select: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 B, 01 constant 4, 10 extended immediate, 11 extended immediate << 2
- imm_zext  out  1  1 = zero-extend immediate (andi/ori), 0 = sign-extend
- alu_op  out  4  0000 add, 0001 subtract/compare, 0010 R-type (funct decides), 0011 addi, 0100 andi, 0101 ori, 0110 slti/sltiu
- state  out  4  current state code (debug)
- illegal  out  1  sticky: an unknown opcode was decoded
- retired  out  32  count of completed instructions

## Operation
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, RTWB 7, IMMEXEC 8, IMMWB 9, BRANCH 10, JUMP 11, HALT 15.
- Outputs are Moore-decoded from the state. The exceptions are ir_write and pc_write in FETCH, which are asserted only when mem_ready=1. Any signal not listed for a state is 0, and alu_op defaults to 0000.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, pc_src=00. On mem_ready, assert ir_write and pc_write and go to DECODE; otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) go to MEMADR.
  - 000000 goes to RTEXEC.
  - 001000, 001100, 001101, 001010, 001011 go to IMMEXEC.
  - 000100 (beq) or 000101 (bne) go to BRANCH.
  - 000010 goes to JUMP.
  - Any other opcode goes to HALT.
- MEMADR: alu_src_a=1, alu_src_b=10. lw goes to MEMRD; sw goes to MEMWR.
- MEMRD: mem_read=1, iord=1. Stay until mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
- MEMWR: mem_write=1, iord=1. Stay until mem_ready, then go to FETCH.
- RTEXEC: alu_src_a=1, alu_src_b=00, alu_op=0010, then go to RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
- IMMEXEC: alu_src_a=1, alu_src_b=10.
  - alu_op: 0011 for addi, 0100 for andi, 0101 for ori, 0110 for slti/sltiu.
  - imm_zext=1 for andi/ori only.
  - Then go to IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0. The alu_op and imm_zext values from IMMEXEC are held here, then go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=0001, pc_write_cond=1, pc_src=01, branch_ne = opcode[0], then go to FETCH.
- JUMP: pc_write=1, pc_src=10, then go to FETCH.
- HALT: all strobes 0, illegal=1. The only exit is reset.
- opcode is sampled directly in each state. The instruction register holds it stable from DECODE until the next FETCH completes.
- retired increments by 1 on every transition into FETCH from MEMWB, MEMWR, RTWB, IMMWB, BRANCH or JUMP. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (async, rst_n low): state=FETCH, illegal=0, retired=0. Outputs immediately show FETCH decode: mem_read=1, alu_src_b=01, alu_op=0000. ir_write and pc_write follow mem_ready.
- Reset deasserting mid-instruction always restarts at FETCH. No partial writes are replayed.
- Cycle counts with mem_ready held at 1: lw 5, sw 4, R-type 4, immediate 4, branch 3, jump 3.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle. Strobes stay asserted and stable throughout the stall.
- mem_ready is ignored in every other state.
- HALT is entered on the clock edge that ends DECODE; illegal rises on that same edge.

## Test plan
- Reset, then hold mem_ready=1 with opcode 100011 → state sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4. retired=1 after 5 cycles.
- opcode 000000 → RTEXEC shows alu_op=0010, RTWB shows reg_dst=1. opcode 001101 → IMMEXEC/IMMWB show alu_op=0101, imm_zext=1.
- sw with mem_ready low for 3 cycles in MEMWR → mem_write=1 and iord=1 for 4 cycles. retired increments once.
- opcode 000101 → BRANCH shows alu_op=0001, branch_ne=1, pc_write_cond=1, pc_src=01. opcode 000010 → JUMP shows pc_src=10, pc_write=1.
- opcode 111111 → state=15 and illegal=1 permanently. Applying rst_n=0 returns state=0, illegal=0, retired=0.
- Stall FETCH with mem_ready=0 → ir_write=0 and pc_write=0 while mem_read=1. Asserting rst_n low mid-MEMRD returns to FETCH asynchronously.
